// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter/sequencer sharing one external combinational ALU.
// Define ALU_ARB_FIXED_PRI_EN to make port 0 win every contention instead of round-robin.
module alu_arbiter #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [DATA_W-1:0] r0_a,
    input  logic [DATA_W-1:0] r0_b,
    input  logic [SEL_W-1:0]  r0_sel,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [DATA_W-1:0] r1_a,
    input  logic [DATA_W-1:0] r1_b,
    input  logic [SEL_W-1:0]  r1_sel,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_carry,
    output logic              rsp_id,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                gnt0_s;
    logic                gnt1_s;
    logic                xfer_s;
    logic [DATA_W-1:0]   alu_a_r;
    logic [DATA_W-1:0]   alu_b_r;
    logic [SEL_W-1:0]    alu_sel_r;
    logic [DATA_W-1:0]   rsp_data_r;
    logic                rsp_carry_r;
    logic                id_r;

`ifndef ALU_ARB_FIXED_PRI_EN
    logic                last_r;

    // Round-robin pointer: remembers which port was granted most recently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_r <= 1'b1;
        end else if (xfer_s) begin
            last_r <= gnt1_s;
        end
    end
`endif

    // Grant decode; ready is the grant itself, so it may follow valid within the cycle.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if ((state_r == IDLE) && !reset) begin
`ifdef ALU_ARB_FIXED_PRI_EN
            gnt0_s = r0_valid;
            gnt1_s = r1_valid & ~r0_valid;
`else
            if (r0_valid && r1_valid) begin
                gnt0_s = last_r;
                gnt1_s = ~last_r;
            end else begin
                gnt0_s = r0_valid;
                gnt1_s = r1_valid;
            end
`endif
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    assign xfer_s = gnt0_s | gnt1_s;

    // Next-state logic for the accept / execute / respond sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (xfer_s) begin
                    state_nxt_s = EXEC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC: state_nxt_s = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand latch on acceptance and result capture during the single EXEC cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_a_r     <= {DATA_W{1'b0}};
            alu_b_r     <= {DATA_W{1'b0}};
            alu_sel_r   <= {SEL_W{1'b0}};
            id_r        <= 1'b0;
            rsp_data_r  <= {DATA_W{1'b0}};
            rsp_carry_r <= 1'b0;
        end else begin
            if (xfer_s) begin
                alu_a_r   <= gnt1_s ? r1_a   : r0_a;
                alu_b_r   <= gnt1_s ? r1_b   : r0_b;
                alu_sel_r <= gnt1_s ? r1_sel : r0_sel;
                id_r      <= gnt1_s;
            end
            if (state_r == EXEC) begin
                rsp_data_r  <= alu_out;
                rsp_carry_r <= alu_carry;
            end
        end
    end

    assign r0_ready  = gnt0_s;
    assign r1_ready  = gnt1_s;
    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign alu_sel   = alu_sel_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_carry = rsp_carry_r;
    assign rsp_id    = id_r;
    assign rsp_valid = (state_r == RESP);
    assign busy      = (state_r == EXEC) || (state_r == RESP);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a small reference ALU attached.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       r0_valid, r0_ready, r1_valid, r1_ready;
    logic [7:0] r0_a, r0_b, r1_a, r1_b;
    logic [3:0] r0_sel, r1_sel;
    logic       rsp_valid, rsp_ready, rsp_carry, rsp_id, busy;
    logic [7:0] rsp_data, alu_a, alu_b, alu_out;
    logic [3:0] alu_sel;
    logic       alu_carry;
    logic [8:0] res9;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(8), .SEL_W(4)) dut (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_sel(r0_sel),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_sel(r1_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_carry(rsp_carry), .rsp_id(rsp_id),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry), .busy(busy)
    );

    // Reference ALU standing in for the external datapath.
    always_comb begin
        res9 = 9'h000;
        case (alu_sel)
            4'h0: res9 = {1'b0, alu_a} + {1'b0, alu_b};
            4'h1: res9 = {1'b0, alu_a} - {1'b0, alu_b};
            4'h2: res9 = {1'b0, alu_a & alu_b};
            4'h3: res9 = {1'b0, alu_a | alu_b};
            4'h4: res9 = {1'b0, alu_a ^ alu_b};
            4'h5: res9 = {1'b0, ~alu_a};
            4'h6: res9 = {alu_a, 1'b0};
            4'h7: res9 = {alu_a[0], 1'b0, alu_a[7:1]};
            4'h8: res9 = {1'b0, alu_a} + 9'd1;
            4'h9: res9 = {1'b0, alu_a} - 9'd1;
            4'hA: res9 = {1'b0, alu_b};
            4'hB: res9 = {1'b0, alu_a};
            4'hC: res9 = {1'b0, ~(alu_a & alu_b)};
            4'hD: res9 = {1'b0, alu_a} + {1'b0, alu_b} + 9'd1;
            4'hE: res9 = {alu_a[7], alu_a[6:0], alu_a[7]};
            4'hF: res9 = 9'h1FF;
            default: res9 = 9'h000;
        endcase
    end
    assign alu_out   = res9[7:0];
    assign alu_carry = res9[8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single request on one port with rsp_ready high; checks latency, busy width and result.
    task automatic do_op(input logic port, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] sel, input logic [7:0] ed, input logic ec);
        rsp_ready = 1'b1;
        if (port) begin
            r1_a = a; r1_b = b; r1_sel = sel; r1_valid = 1'b1;
        end else begin
            r0_a = a; r0_b = b; r0_sel = sel; r0_valid = 1'b1;
        end
        #1;
        chk("op_r0_ready", r0_ready, !port);
        chk("op_r1_ready", r1_ready, port);
        step();
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        chk("exec_busy", busy, 1'b1);
        chk("exec_rsp_valid", rsp_valid, 1'b0);
        chk("exec_alu_a", alu_a, a);
        chk("exec_alu_b", alu_b, b);
        chk("exec_alu_sel", alu_sel, sel);
        step();
        chk("resp_valid", rsp_valid, 1'b1);
        chk("resp_busy", busy, 1'b1);
        chk("resp_data", rsp_data, ed);
        chk("resp_carry", rsp_carry, ec);
        chk("resp_id", rsp_id, port);
        step();
        chk("done_busy", busy, 1'b0);
        chk("done_rsp_valid", rsp_valid, 1'b0);
    endtask

    logic [7:0] sweep_d [16] = '{8'h0C, 8'h08, 8'h02, 8'h0A, 8'h08, 8'hF5, 8'h14, 8'h05,
                                 8'h0B, 8'h09, 8'h02, 8'h0A, 8'hFD, 8'h0D, 8'h14, 8'hFF};
    logic       sweep_c [16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        logic exp_id;
        reset = 1'b1;
        r0_valid = 1'b1; r1_valid = 1'b1; rsp_ready = 1'b0;
        r0_a = 8'h00; r0_b = 8'h00; r0_sel = 4'h0;
        r1_a = 8'h00; r1_b = 8'h00; r1_sel = 4'h0;
        step();
        step();
        chk("rst_r0_ready", r0_ready, 1'b0);
        chk("rst_r1_ready", r1_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_alu_a", alu_a, 8'h00);
        chk("rst_rsp_data", rsp_data, 8'h00);
        r0_valid = 1'b0; r1_valid = 1'b0;
        reset = 1'b0;
        step();

        do_op(1'b0, 8'h0A, 8'h02, 4'h0, 8'h0C, 1'b0);
        do_op(1'b1, 8'hF6, 8'h0A, 4'h0, 8'h00, 1'b1);

        // Contention: both ports held valid for four operations.
        r0_a = 8'h01; r0_b = 8'h01; r0_sel = 4'h0;
        r1_a = 8'h10; r1_b = 8'h20; r1_sel = 4'h3;
        r0_valid = 1'b1; r1_valid = 1'b1; rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRI_EN
            exp_id = 1'b0;
`else
            exp_id = k[0];
`endif
            chk("cont_r0_ready", r0_ready, !exp_id);
            chk("cont_r1_ready", r1_ready, exp_id);
            step();
            chk("cont_alu_a", alu_a, exp_id ? 8'h10 : 8'h01);
            step();
            chk("cont_rsp_id", rsp_id, exp_id);
            chk("cont_rsp_data", rsp_data, exp_id ? 8'h30 : 8'h02);
            step();
        end
        r0_valid = 1'b0; r1_valid = 1'b0;
        step();

        // Backpressure while port 1 waits.
        rsp_ready = 1'b0;
        r0_a = 8'h33; r0_b = 8'h11; r0_sel = 4'h1; r0_valid = 1'b1;
        step();
        r0_valid = 1'b0;
        r1_a = 8'h05; r1_b = 8'h07; r1_sel = 4'h1; r1_valid = 1'b1;
        step();
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_valid", rsp_valid, 1'b1);
            chk("bp_rsp_data", rsp_data, 8'h22);
            chk("bp_rsp_carry", rsp_carry, 1'b0);
            chk("bp_rsp_id", rsp_id, 1'b0);
            chk("bp_alu_a", alu_a, 8'h33);
            chk("bp_alu_b", alu_b, 8'h11);
            chk("bp_alu_sel", alu_sel, 4'h1);
            chk("bp_r0_ready", r0_ready, 1'b0);
            chk("bp_r1_ready", r1_ready, 1'b0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("hs_r1_ready", r1_ready, 1'b0);
        step();
        chk("post_hs_rsp_valid", rsp_valid, 1'b0);
        chk("post_hs_r1_ready", r1_ready, 1'b1);
        step();
        r1_valid = 1'b0;
        chk("bp_p1_alu_a", alu_a, 8'h05);
        step();
        chk("bp_p1_data", rsp_data, 8'hFE);
        chk("bp_p1_carry", rsp_carry, 1'b1);
        chk("bp_p1_id", rsp_id, 1'b1);
        step();

        // Port 0 op to move the pointer, then reset during its EXEC cycle.
        r0_a = 8'h5A; r0_b = 8'hA5; r0_sel = 4'h4; r0_valid = 1'b1;
        step();
        r0_valid = 1'b0;
        chk("pre_rst_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_alu_a", alu_a, 8'h00);
        chk("mid_rst_alu_b", alu_b, 8'h00);
        chk("mid_rst_alu_sel", alu_sel, 4'h0);
        chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
        chk("mid_rst_rsp_data", rsp_data, 8'h00);
        chk("mid_rst_rsp_carry", rsp_carry, 1'b0);
        chk("mid_rst_rsp_id", rsp_id, 1'b0);
        step();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_rst_no_rsp", rsp_valid, 1'b0);
        end
        r0_a = 8'h01; r0_b = 8'h02; r0_sel = 4'h0;
        r1_a = 8'h03; r1_b = 8'h04; r1_sel = 4'h0;
        r0_valid = 1'b1; r1_valid = 1'b1;
        #1;
        chk("post_rst_r0_ready", r0_ready, 1'b1);
        chk("post_rst_r1_ready", r1_ready, 1'b0);
        step();
        r0_valid = 1'b0; r1_valid = 1'b0;
        step();
        chk("post_rst_rsp_id", rsp_id, 1'b0);
        chk("post_rst_rsp_data", rsp_data, 8'h03);
        step();

        // Select sweep on port 0.
        for (int s = 0; s < 16; s++) begin
            do_op(1'b0, 8'h0A, 8'h02, s[3:0], sweep_d[s], sweep_c[s]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
